// File: rtl/uart_pkg.sv
// uart_pkg: constants and state encoding shared by the UART transmitter, receiver and tick generator
//   NUM_TICKS : oversampling ticks per bit
//   state_t   : 3-bit FSM encoding IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
package uart_pkg;
  localparam int NUM_TICKS = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter (start, DATA_BITS LSB first, optional parity, stop period) timed by a 16x tick
//   i_clock    : system clock, posedge
//   i_reset    : asynchronous active-low reset
//   i_tick     : 16x baud tick, one-cycle pulse
//   i_tx_start : send request, sampled only in IDLE
//   i_data     : frame payload, latched on acceptance
//   o_tx       : registered serial line, idles high
//   o_tx_busy  : high from acceptance until return to IDLE
//   o_tx_done  : one-cycle pulse when the stop period ends
//   UART_TX_PARITY_EN : when defined, adds a parity bit (even, or odd with PARITY_ODD=1)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
`ifdef UART_TX_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);
  state_t               state;
  logic [4:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  logic                 stop_end;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif
  assign bit_end  = i_tick && tick_cnt == 5'(NUM_TICKS - 1);
  assign stop_end = i_tick && tick_cnt == 5'(STOP_TICKS - 1);
  // o_tx is loaded with the value of the bit being entered, so the line is registered with no extra latency
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      o_tx_done <= 1'b0;
      case (state)
        IDLE: if (i_tx_start) begin
          shreg     <= i_data;
`ifdef UART_TX_PARITY_EN
          // parity of the latched byte, captured before shifting destroys it
          par       <= ^i_data ^ 1'(PARITY_ODD);
`endif
          tick_cnt  <= '0;
          state     <= START;
          o_tx      <= 1'b0;
          o_tx_busy <= 1'b1;
        end
        START: if (bit_end) begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          state    <= DATA;
          o_tx     <= shreg[0];
        end else if (i_tick) tick_cnt <= tick_cnt + 5'd1;
        DATA: if (bit_end) begin
          tick_cnt <= '0;
          shreg    <= shreg >> 1;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            o_tx  <= par;
`else
            state <= STOP;
            o_tx  <= 1'b1;
`endif
          end else o_tx <= shreg[1];
        end else if (i_tick) tick_cnt <= tick_cnt + 5'd1;
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          tick_cnt <= '0;
          state    <= STOP;
          o_tx     <= 1'b1;
        end else if (i_tick) tick_cnt <= tick_cnt + 5'd1;
`endif
        STOP: if (stop_end) begin
          tick_cnt  <= '0;
          state     <= IDLE;
          o_tx_busy <= 1'b0;
          o_tx_done <= 1'b1;
        end else if (i_tick) tick_cnt <= tick_cnt + 5'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a tick-count model of the frame
module tb_uart_tx;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int ST = 32, PO = 0, PB = 1, LEN_LIT = 192;
`else
  localparam int ST = 16, PB = 0, LEN_LIT = 160;
`endif
  localparam int NB = 1 + DB + PB;
  localparam int TOTAL = 16 * NB + ST;
  logic clk = 0, rst_n = 0, tick = 0, start = 0;
  logic [DB-1:0] data = '0;
  logic tx, busy, done;
  int chk_n = 0, err_n = 0, div = 1, tcnt = 0, frames = 0;
  logic m_active = 0, m_done = 0;
  int m_t = 0;
  logic [DB-1:0] m_data = '0;
  logic q[$];
  logic [DB-1:0] last_data = '0;
  int last_len = 0;
  logic last_ok = 0, last_par = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(DB), .STOP_TICKS(ST)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(PO)
`endif
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_tx_start(start),
    .i_data(data), .o_tx(tx), .o_tx_busy(busy), .o_tx_done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // a frame is TOTAL ticks long; the line level is a pure function of ticks elapsed since acceptance
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (start) begin m_active = 1; m_data = data; m_t = 0; end
      end else if (tick) begin
        m_t++;
        if (m_t == TOTAL) begin m_active = 0; m_done = 1; end
      end
    end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / 16;
    if (b == 0) return 1'b0;
    if (b <= DB) return m_data[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DB + 1) return ^m_data ^ 1'(PO);
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    check("tx", {31'b0, tx}, {31'b0, exp_tx()});
    check("busy", {31'b0, busy}, {31'b0, m_active});
    check("done", {31'b0, done}, {31'b0, m_done});
  end

  // records the line at every consumed tick and decodes bit centres when a frame completes
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else if (done) begin
      last_len = q.size();
      if (q.size() == TOTAL) begin
        for (int i = 0; i < DB; i++) last_data[i] = q[16*(i+1)+8];
        last_ok  = (q[8] == 1'b0) && (q[16*NB+8] == 1'b1);
        last_par = q[16*(DB+1)+8];
      end else begin
        last_data = 'x; last_ok = 0;
      end
      frames++;
      q.delete();
    end else if (busy && tick) q.push_back(tx);
  end

  always @(posedge clk) begin
    #2;
    if (tcnt >= div) begin tick = 1; tcnt = 0; end
    else begin tick = 0; tcnt++; end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [DB-1:0] d);
    @(posedge clk); #2;
    start = 1; data = d;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic wait_frame(input string name);
    int f0, n;
    f0 = frames; n = 0;
    while (frames == f0 && n < 20000) begin @(posedge clk); n++; end
    #2;
    check(name, frames - f0, 1);
  endtask

  initial begin
    int f0, n;
    logic [DB-1:0] d;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'b0, tx}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    @(posedge clk); #2 rst_n = 1;

    div = 1;
    send(8'h55);
    wait_frame("f55_timeout");
    check("f55_len", last_len, LEN_LIT);
    check("f55_data", last_data, 8'h55);
    check("f55_framing", last_ok, 1);
    check("f55_count", frames, 1);

    send(8'hA3);
    step(40);
    start = 1; data = 8'hFF;
    step(1);
    start = 0;
    wait_frame("fa3_timeout");
    check("fa3_data", last_data, 8'hA3);
    step(30);
    check("fa3_single", frames, 2);
    check("fa3_idle", {31'b0, busy}, 0);

    div = 0;
    @(posedge clk); #2;
    start = 1; data = 8'h00;
    step(3);
    data = 8'hFF;
    wait_frame("b2b0_timeout");
    check("b2b0_data", last_data, 8'h00);
    @(negedge clk);
    check("b2b_gap_tx", {31'b0, tx}, 0);
    check("b2b_gap_busy", {31'b0, busy}, 1);
    start = 0;
    wait_frame("b2b1_timeout");
    check("b2b1_data", last_data, 8'hFF);
    check("b2b1_len", last_len, LEN_LIT);

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_frame("par_timeout");
    check("par_bit", last_par, 1);
    check("par_len", last_len, 192);
`endif

    div = 1;
    send(8'h96);
    n = 0;
    while (q.size() < 16*4 + 6 && n < 5000) begin @(posedge clk); n++; end
    check("mid_reach", {31'b0, q.size() >= 16*4 + 6}, 1);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("mid_rst_tx", {31'b0, tx}, 1);
    check("mid_rst_busy", {31'b0, busy}, 0);
    f0 = frames;
    step(3);
    rst_n = 1;
    step(2);
    send(8'h3C);
    wait_frame("f3c_timeout");
    check("f3c_data", last_data, 8'h3C);
    check("f3c_nodone", frames, f0 + 1);

    for (int i = 0; i < 20; i++) begin
      div = $urandom_range(0, 3);
      d = DB'($urandom);
      send(d);
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(5, 60));
        start = 1; data = DB'($urandom);
        step(1);
        start = 0;
      end
      wait_frame("rnd_timeout");
      check("rnd_data", last_data, d);
      check("rnd_len", last_len, TOTAL);
      step($urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end
endmodule
